// File: rtl/sine_sequencer.sv
// Quarter-wave sine sequencer: walks the LUT address up/down through four quadrants
// at a programmable tick rate, with period-aligned start/stop and shadowed rate reloads.
module sine_sequencer #(
    parameter int ADDR_W = 6,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div,
    input  logic              cfg_load,
    output logic [ADDR_W-1:0] addr,
    output logic              sign,
    output logic              signB,
    output logic              sample_valid,
    output logic              period_start,
    output logic              busy,
    output logic              cfg_pending
);

    localparam logic [ADDR_W-1:0] MAX = '1;

    typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               sign_q, sign_d;
    logic               sign_b_q;
    logic               sv_q, sv_d;
    logic               ps_q, ps_d;
    logic               busy_q, busy_d;
    logic               pend_q, pend_d;
    logic [DIV_W-1:0]   shadow_q, shadow_d;
    logic [DIV_W-1:0]   div_act_q, div_act_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               tick;
    logic               apply;

    assign tick = (cnt_q == div_act_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sign_d    = sign_q;
        sv_d      = 1'b0;
        ps_d      = 1'b0;
        busy_d    = busy_q;
        pend_d    = pend_q;
        shadow_d  = shadow_q;
        div_act_d = div_act_q;
        cnt_d     = cnt_q;
        apply     = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (enable) begin
                    state_d = Q0;
                    addr_d  = '0;
                    sign_d  = 1'b0;
                    sv_d    = 1'b1;
                    ps_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    apply   = 1'b1;
                end
            end
            default: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    sv_d = 1'b1;
                    case (state_q)
                        Q0: begin
                            if (addr_q != MAX) addr_d = addr_q + 1'b1;
                            else               state_d = Q1;
                        end
                        Q1: begin
                            if (addr_q != '0) addr_d = addr_q - 1'b1;
                            else begin
                                state_d = Q2;
                                sign_d  = 1'b1;
                            end
                        end
                        Q2: begin
                            if (addr_q != MAX) addr_d = addr_q + 1'b1;
                            else               state_d = Q3;
                        end
                        Q3: begin
                            if (addr_q != '0) addr_d = addr_q - 1'b1;
                            else if (enable) begin
                                // Period end with run request: wrap straight into Q0.
                                state_d = Q0;
                                addr_d  = '0;
                                sign_d  = 1'b0;
                                ps_d    = 1'b1;
                                apply   = 1'b1;
                            end else begin
                                state_d = IDLE;
                                addr_d  = '0;
                                sign_d  = 1'b0;
                                sv_d    = 1'b0;
                                busy_d  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        if (apply && pend_q) begin
            div_act_d = shadow_q;
            pend_d    = 1'b0;
        end
        // A load coinciding with an application stays pending for the next boundary.
        if (cfg_load) begin
            shadow_d = div;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            sign_q    <= 1'b0;
            sign_b_q  <= 1'b1;
            sv_q      <= 1'b0;
            ps_q      <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            shadow_q  <= '0;
            div_act_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sign_q    <= sign_d;
            sign_b_q  <= ~sign_d;
            sv_q      <= sv_d;
            ps_q      <= ps_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            shadow_q  <= shadow_d;
            div_act_q <= div_act_d;
            cnt_q     <= cnt_d;
        end
    end

    assign addr         = addr_q;
    assign sign         = sign_q;
    assign signB        = sign_b_q;
    assign sample_valid = sv_q;
    assign period_start = ps_q;
    assign busy         = busy_q;
    assign cfg_pending  = pend_q;

endmodule

// File: tb/tb_sine_sequencer.sv
// Directed bench for sine_sequencer with a 2-bit address (16-sample period).
module tb_sine_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] div;
    logic        cfg_load;
    logic [1:0]  addr;
    logic        sign;
    logic        signB;
    logic        sample_valid;
    logic        period_start;
    logic        busy;
    logic        cfg_pending;

    int checks = 0;
    int errors = 0;

    // Address shown after each sample tick within one period.
    int exp_addr [16] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3, 3, 2, 1, 0};

    sine_sequencer #(.ADDR_W(2), .DIV_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .div          (div),
        .cfg_load     (cfg_load),
        .addr         (addr),
        .sign         (sign),
        .signB        (signB),
        .sample_valid (sample_valid),
        .period_start (period_start),
        .busy         (busy),
        .cfg_pending  (cfg_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_sign", 32'(sign), 32'd0);
        chk("rst_signB", 32'(signB), 32'd1);
        chk("rst_sv", 32'(sample_valid), 32'd0);
        chk("rst_ps", 32'(period_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pend", 32'(cfg_pending), 32'd0);
    endtask

    task automatic chk_start(input logic pend_exp);
        chk("start_ps", 32'(period_start), 32'd1);
        chk("start_sv", 32'(sample_valid), 32'd1);
        chk("start_addr", 32'(addr), 32'd0);
        chk("start_sign", 32'(sign), 32'd0);
        chk("start_signB", 32'(signB), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_pend", 32'(cfg_pending), 32'(pend_exp));
    endtask

    // Checks cycles 1..last_k after a period_start, with a tick every sp cycles.
    task automatic check_period(input int sp, input int last_k, input int drop_at,
                                input int load_at, input logic [15:0] load_val,
                                input logic pend0);
        logic pe;
        int   idx;
        pe = pend0;
        for (int k = 1; k <= last_k; k++) begin
            cyc();
            if (k == load_at + 1) begin
                cfg_load = 1'b0;
                pe = 1'b1;
            end
            idx = k / sp;
            chk("addr", 32'(addr), 32'(exp_addr[idx]));
            chk("sign", 32'(sign), 32'(idx >= 8));
            chk("signB", 32'(signB), 32'(idx < 8));
            chk("sample_valid", 32'(sample_valid), 32'((k % sp) == 0));
            chk("period_start", 32'(period_start), 32'd0);
            chk("busy", 32'(busy), 32'd1);
            chk("cfg_pending", 32'(cfg_pending), 32'(pe));
            if (k == drop_at) enable = 1'b0;
            if (k == load_at) begin
                cfg_load = 1'b1;
                div = load_val;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        div = 16'd0;
        cfg_load = 1'b0;
        #2;
        chk_reset_outputs();
        cyc();
        cyc();
        rst = 1'b0;

        // Rate 0 loaded while idle, then start.
        div = 16'd0;
        cfg_load = 1'b1;
        cyc();
        chk("load_idle_pend", 32'(cfg_pending), 32'd1);
        chk("load_idle_busy", 32'(busy), 32'd0);
        cfg_load = 1'b0;
        enable = 1'b1;
        cyc();
        chk_start(1'b0);
        check_period(1, 15, -1, -1, 16'd0, 1'b0);
        cyc();
        chk_start(1'b0);

        // Load div=2 during the second period; takes effect at the next start.
        check_period(1, 15, -1, 3, 16'd2, 1'b0);
        cyc();
        chk_start(1'b0);
        check_period(3, 47, -1, -1, 16'd0, 1'b0);
        cyc();
        chk_start(1'b0);

        // Drop enable in Q1: period completes, then idle.
        check_period(3, 47, 15, -1, 16'd0, 1'b0);
        cyc();
        chk_reset_outputs();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_sv", 32'(sample_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_addr", 32'(addr), 32'd0);
        end

        // Return to rate 0 while idle, then restart.
        div = 16'd0;
        cfg_load = 1'b1;
        cyc();
        chk("reload_pend", 32'(cfg_pending), 32'd1);
        cfg_load = 1'b0;
        enable = 1'b1;
        cyc();
        chk_start(1'b0);

        // Load div=1 mid-Q2; pending until next start.
        check_period(1, 15, -1, 9, 16'd1, 1'b0);
        cyc();
        chk_start(1'b0);

        // Load div=3 on the period-end tick: stays pending one more period.
        check_period(2, 31, -1, 31, 16'd3, 1'b0);
        cyc();
        cfg_load = 1'b0;
        chk_start(1'b1);
        div = 16'd7;
        check_period(2, 31, -1, -1, 16'd0, 1'b1);
        cyc();
        chk_start(1'b0);

        // Async reset in Q3 with addr=2.
        check_period(4, 53, -1, -1, 16'd0, 1'b0);
        chk("pre_rst_addr", 32'(addr), 32'd2);
        chk("pre_rst_sign", 32'(sign), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        cyc();
        chk_reset_outputs();
        rst = 1'b0;
        cyc();
        chk_start(1'b0);
        check_period(1, 15, -1, -1, 16'd0, 1'b0);
        cyc();
        chk_start(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
